// File: rtl/alu_sequencer_if.sv
// Bus between the command source, the alu_sequencer and the ALU datapath.
//   cmd_*  : valid/ready command port (opcode + B operand)
//   rsp_*  : valid/ready response port (32-bit result, error, overflow)
//   alu_*  : operand data, one-hot mux selects and opcode select toward the
//            datapath, plus its combinational 32-bit result
// modport slave  : the sequencer side
// modport master : the host/datapath side (testbench)
interface alu_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_operand;

  logic [15:0] alu_a_data;
  logic [15:0] alu_b_data;
  logic [1:0]  alu_a_sel;
  logic [3:0]  alu_b_sel;
  logic [15:0] alu_op_sel;
  logic [31:0] alu_result;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_ovf;

  modport slave (
    input  cmd_valid, cmd_op, cmd_operand, rsp_ready, alu_result,
    output cmd_ready, alu_a_data, alu_b_data, alu_a_sel, alu_b_sel,
           alu_op_sel, rsp_valid, rsp_data, rsp_err, rsp_ovf
  );

  modport master (
    output cmd_valid, cmd_op, cmd_operand, rsp_ready, alu_result,
    input  cmd_ready, alu_a_data, alu_b_data, alu_a_sel, alu_b_sel,
           alu_op_sel, rsp_valid, rsp_data, rsp_err, rsp_ovf
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one command at a time, walks the 16-bit ALU datapath
// through an operand-load cycle and an execute cycle, folds the low half of
// the 32-bit result into the accumulator and returns the full result.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : alu_sequencer_if.slave (command, response and datapath signals)
//   busy  : high whenever the sequencer is not idle
module alu_sequencer (
  input  logic             clk,
  input  logic             reset,
  alu_sequencer_if.slave   bus,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, RESP} state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_MULT = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd11;
  localparam logic [3:0] OP_LAST = 4'd12;  // highest op sent to the datapath
  localparam logic [3:0] OP_NOP  = 4'd13;
  localparam logic [3:0] OP_CLR  = 4'd15;

  state_t      state, state_nxt;
  logic [15:0] acc;
  logic [3:0]  op_q;
  logic [15:0] operand_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;
  logic        rsp_ovf_q;

  logic        cmd_ready_c;
  logic        rsp_valid_c;
  logic [1:0]  a_sel_c;
  logic [3:0]  b_sel_c;
  logic [15:0] op_sel_c;
  logic        issue_c;

  // Only add, mult and shl can legitimately grow past 16 bits.
  function automatic logic ovf_of(input logic [3:0] op, input logic [31:0] res);
    return ((op == OP_ADD) || (op == OP_MULT) || (op == OP_SHL)) && (|res[31:16]);
  endfunction

  // Divide by zero is answered locally so the datapath never sees it.
  assign issue_c = (bus.cmd_op <= OP_LAST) &&
                   !((bus.cmd_op == OP_DIV) && (bus.cmd_operand == 16'd0));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    a_sel_c     = 2'b01;
    b_sel_c     = 4'b0001;
    op_sel_c    = 16'd0;
    case (state)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) state_nxt = issue_c ? LOAD : RESP;
      end
      LOAD: begin
        a_sel_c   = 2'b10;
        b_sel_c   = 4'b0100;
        state_nxt = EXEC;
      end
      EXEC: begin
        op_sel_c  = 16'd1 << op_q;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= 16'd0;
      op_q       <= 4'd0;
      operand_q  <= 16'd0;
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 1'b0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q      <= bus.cmd_op;
            operand_q <= bus.cmd_operand;
            // Non-issued ops produce their response right at accept.
            if (!issue_c) begin
              rsp_ovf_q <= 1'b0;
              if (bus.cmd_op == OP_CLR) begin
                acc        <= 16'd0;
                rsp_data_q <= 32'd0;
                rsp_err_q  <= 1'b0;
              end else begin
                rsp_data_q <= {16'd0, acc};
                rsp_err_q  <= (bus.cmd_op != OP_NOP);
              end
            end
          end
        end
        EXEC: begin
          rsp_data_q <= bus.alu_result;
          acc        <= bus.alu_result[15:0];
          rsp_ovf_q  <= ovf_of(op_q, bus.alu_result);
          rsp_err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_c;
  assign bus.rsp_valid  = rsp_valid_c;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_ovf    = rsp_ovf_q;
  assign bus.alu_a_data = acc;
  assign bus.alu_b_data = operand_q;
  assign bus.alu_a_sel  = a_sel_c;
  assign bus.alu_b_sel  = b_sel_c;
  assign bus.alu_op_sel = op_sel_c;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural model of the
// ALU datapath (operand registers + one-hot result mux).
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   tests  = 0;
  int   failed = 0;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Datapath model: operand registers load on the select, result is combinational.
  logic [15:0] dp_a = 16'd0;
  logic [15:0] dp_b = 16'd0;
  always @(posedge clk) begin
    if (bus.alu_a_sel == 2'b10)   dp_a <= bus.alu_a_data;
    if (bus.alu_b_sel == 4'b0100) dp_b <= bus.alu_b_data;
  end

  always_comb begin
    bus.alu_result = 32'd0;
    case (bus.alu_op_sel)
      16'h0001: bus.alu_result = {16'd0, dp_a} + {16'd0, dp_b};
      16'h0002: bus.alu_result = {16'd0, dp_a} - {16'd0, dp_b};
      16'h0004: bus.alu_result = {16'd0, dp_a} * {16'd0, dp_b};
      16'h0008: bus.alu_result = {16'd0, dp_a / dp_b};
      16'h0010: bus.alu_result = {16'd0, dp_a & dp_b};
      16'h0020: bus.alu_result = {16'd0, dp_a | dp_b};
      16'h0040: bus.alu_result = {16'd0, dp_a ^ dp_b};
      default:  bus.alu_result = 32'd0;
    endcase
  end

  // Sticky observations, cleared by the stimulus before each command.
  logic seen_div_sel = 1'b0;
  logic seen_load    = 1'b0;
  logic seen_rsp     = 1'b0;
  always @(negedge clk) begin
    if (bus.alu_op_sel[3])        seen_div_sel = 1'b1;
    if (bus.alu_a_sel == 2'b10)   seen_load    = 1'b1;
    if (bus.rsp_valid)            seen_rsp     = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a command and let it be accepted; returns just after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [15:0] operand);
    int n;
    @(negedge clk);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_operand = operand;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  // Count negedges after the accept edge until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 50);
    if (lat >= 50) check("rsp_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_cmd(input logic [3:0] op, input logic [15:0] operand,
                        output logic [31:0] data, output logic err,
                        output logic ovf, output int lat);
    bus.rsp_ready = 1'b1;
    seen_div_sel  = 1'b0;
    seen_load     = 1'b0;
    issue(op, operand);
    wait_rsp(lat);
    data = bus.rsp_data;
    err  = bus.rsp_err;
    ovf  = bus.rsp_ovf;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] d;
  logic        e, o;
  int          lat;

  initial begin
    reset           = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 4'd0;
    bus.cmd_operand = 16'd0;
    bus.rsp_ready   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_a_sel",     32'(bus.alu_a_sel), 32'h1);
    check("rst_b_sel",     32'(bus.alu_b_sel), 32'h1);
    check("rst_op_sel",    32'(bus.alu_op_sel), 32'h0);
    check("rst_a_data",    32'(bus.alu_a_data), 32'h0);
    check("rst_b_data",    32'(bus.alu_b_data), 32'h0);
    check("rst_rsp_data",  bus.rsp_data,        32'h0);
    check("rst_err_ovf",   {30'd0, bus.rsp_err, bus.rsp_ovf}, 32'h0);
    reset = 1'b0;

    // add 5, add 7
    do_cmd(4'd0, 16'd5, d, e, o, lat);
    check("add5_data", d, 32'd5);
    check("add5_lat",  32'(lat), 32'd3);
    do_cmd(4'd0, 16'd7, d, e, o, lat);
    check("add7_data", d, 32'd12);
    check("add7_lat",  32'(lat), 32'd3);
    check("add7_err_ovf", {30'd0, e, o}, 32'd0);
    check("acc_12", 32'(bus.alu_a_data), 32'd12);

    // divide by zero, then div 4
    do_cmd(4'd3, 16'd0, d, e, o, lat);
    check("div0_err",  32'(e), 32'd1);
    check("div0_data", d, 32'd12);
    check("div0_lat",  32'(lat), 32'd1);
    check("div0_nosel", 32'(seen_div_sel), 32'd0);
    check("div0_acc",  32'(bus.alu_a_data), 32'd12);
    do_cmd(4'd3, 16'd4, d, e, o, lat);
    check("div4_data", d, 32'd3);
    check("div4_err",  32'(e), 32'd0);

    // overflow: clear, or 0xFFFF, add 1; then or 0x100, mult 0x100
    do_cmd(4'd15, 16'd0, d, e, o, lat);
    do_cmd(4'd5, 16'hFFFF, d, e, o, lat);
    check("or_ffff", d, 32'h0000FFFF);
    do_cmd(4'd0, 16'd1, d, e, o, lat);
    check("addovf_data", d, 32'h00010000);
    check("addovf_ovf",  32'(o), 32'd1);
    check("addovf_acc",  32'(bus.alu_a_data), 32'd0);
    do_cmd(4'd5, 16'h0100, d, e, o, lat);
    check("or_100_ovf", 32'(o), 32'd0);
    do_cmd(4'd2, 16'h0100, d, e, o, lat);
    check("mult_data", d, 32'h00010000);
    check("mult_ovf",  32'(o), 32'd1);
    check("mult_acc",  32'(bus.alu_a_data), 32'd0);

    // response stall with a second command waiting
    bus.rsp_ready = 1'b0;
    issue(4'd0, 16'd2);
    wait_rsp(lat);
    check("stall_lat", 32'(lat), 32'd3);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = 4'd0;
    bus.cmd_operand = 16'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_ready", 32'(bus.cmd_ready), 32'd0);
      check("stall_data",  bus.rsp_data, 32'd2);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_hs_idle", 32'(bus.cmd_ready), 32'd1);
    check("post_hs_acc",  32'(bus.alu_a_data), 32'd2);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    check("second_acc_busy", 32'(busy), 32'd1);
    wait_rsp(lat);
    check("second_lat",  32'(lat), 32'd3);
    check("second_data", bus.rsp_data, 32'd5);
    @(posedge clk);
    #1;

    // clear, no-op, error
    do_cmd(4'd15, 16'd0, d, e, o, lat);
    check("clr_data", d, 32'd0);
    check("clr_err",  32'(e), 32'd0);
    check("clr_lat",  32'(lat), 32'd1);
    check("clr_noload", 32'(seen_load), 32'd0);
    do_cmd(4'd13, 16'd9, d, e, o, lat);
    check("nop_data", d, 32'd0);
    check("nop_err",  32'(e), 32'd0);
    check("nop_lat",  32'(lat), 32'd1);
    check("nop_noload", 32'(seen_load), 32'd0);
    do_cmd(4'd14, 16'd9, d, e, o, lat);
    check("err_data", d, 32'd0);
    check("err_err",  32'(e), 32'd1);
    check("err_lat",  32'(lat), 32'd1);
    check("err_noload", 32'(seen_load), 32'd0);

    // reset in the EXEC cycle of a mult
    do_cmd(4'd5, 16'd7, d, e, o, lat);
    check("or7_data", d, 32'd7);
    issue(4'd2, 16'd3);
    @(negedge clk);
    @(negedge clk);
    check("exec_op_sel", 32'(bus.alu_op_sel), 32'h0004);
    reset = 1'b1;
    seen_rsp = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    check("rexec_ready", 32'(bus.cmd_ready), 32'd1);
    check("rexec_valid", 32'(bus.rsp_valid), 32'd0);
    check("rexec_acc",   32'(bus.alu_a_data), 32'd0);
    check("rexec_busy",  32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    check("rexec_norsp", 32'(seen_rsp), 32'd0);
    do_cmd(4'd0, 16'd4, d, e, o, lat);
    check("after_rst_add", d, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven controller for the 16-bit accumulator ALU datapath. It accepts one operation at a time on a valid/ready command port and sequences the datapath through an operand-load cycle and an execute cycle. It drives the datapath's A/B operand mux selects, operand data and one-hot opcode select, then captures the 32-bit result into its 16-bit accumulator and returns it on a valid/ready response port. It sits between a host/testbench command source and the existing ALU datapath, replacing hand-driven mux selects and opcodes.

## Interface
Parameters:
- none; the datapath is fixed at 16-bit operands and a 32-bit result.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  4  opcode: 0 add, 1 sub, 2 mult, 3 div, 4 and, 5 or, 6 xor, 7 not, 8 nand, 9 nor, 10 xnor, 11 shl, 12 shr, 13 no-op, 14 error, 15 clear
- cmd_operand  in  16  B operand
- alu_a_data  out  16  A operand to datapath, always equals acc
- alu_b_data  out  16  B operand to datapath, holds the latched operand
- alu_a_sel  out  2  one-hot A mux select: 2'b10 load, 2'b01 hold
- alu_b_sel  out  4  one-hot B mux select: 4'b0100 load, 4'b0001 hold
- alu_op_sel  out  16  one-hot opcode select to the result mux
- alu_result  in  32  combinational datapath result
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  32  full 32-bit result (or acc for non-issued ops)
- rsp_err  out  1  error op or divide by zero
- rsp_ovf  out  1  result[31:16] nonzero for ops 0, 2, 11
- busy  out  1  state != IDLE

## Operation
- State machine: IDLE, LOAD, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cmd_op and cmd_operand.
  - Issued ops (0–12, excluding div by zero) go to LOAD.
  - Ops 13, 14, 15, and op 3 with operand 0, go directly to RESP.
- LOAD:
  - alu_a_sel=2'b10, alu_b_sel=4'b0100, alu_op_sel=0.
  - The datapath operand registers capture acc and the operand on this edge.
  - Next state EXEC.
- EXEC:
  - alu_op_sel = 1 << op, selects held.
  - At the edge: rsp_data <= alu_result; acc <= alu_result[15:0]; rsp_ovf computed; rsp_err=0.
  - Next state RESP.
- RESP:
  - rsp_valid=1; rsp_data, rsp_err and rsp_ovf stay stable until rsp_valid && rsp_ready, then IDLE.
  - cmd_ready=0, so a new command is never accepted in the same cycle as the response handshake.
- Non-issued ops:
  - 13: rsp_data={16'b0,acc}, err=0, acc unchanged.
  - 14: rsp_data={16'b0,acc}, err=1, acc unchanged.
  - 15: acc<=0, rsp_data=0, err=0.
  - div by zero: rsp_data={16'b0,acc}, err=1, acc unchanged, datapath never sees op 3.
- Outside LOAD: alu_a_sel=2'b01 and alu_b_sel=4'b0001 (hold). Outside EXEC: alu_op_sel=0, so the datapath result reads 0.
- Arithmetic semantics belong to the datapath. The sequencer only checks divisor==0 and truncates to 16 bits for acc. The accumulator wraps modulo 2^16.

## Timing
- Reset values: state IDLE, acc=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_ovf=0, busy=0, alu_a_sel=2'b01, alu_b_sel=4'b0001, alu_op_sel=0, alu_a_data=0, alu_b_data=0.
- Issued op: accept edge T, LOAD during T+1, EXEC during T+2, rsp_valid high from T+3. Minimum 4 cycles per command with rsp_ready tied high.
- Non-issued op: rsp_valid high from T+1. Minimum 2 cycles per command.
- rsp_ready low: the block stalls in RESP indefinitely with outputs frozen.
- reset asserted in any state: next edge applies reset values. An in-flight command and a pending response are dropped.
- reset has priority over a cmd handshake in the same cycle.
- alu_result is sampled only at the EXEC edge; the datapath has one cycle of combinational budget.

## Test plan
- Reset, then cmd add 5, then add 7 with rsp_ready=1 -> rsp_data 5, then 12; rsp_valid exactly 3 cycles after each accept; acc=12.
- acc=12, cmd div 0 -> rsp_err=1, rsp_data=12, alu_op_sel never has bit 3 set, acc stays 12; then div 4 -> rsp_data 3.
- acc=0xFFFF, cmd add 1 -> rsp_data 0x00010000, rsp_ovf=1, acc=0; mult 0x100 with acc=0x100 -> rsp_data 0x10000, ovf=1.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> cmd_ready=0, rsp_data stable; a cmd_valid presented meanwhile is accepted only after the handshake.
- Cmd 15 then 13 then 14 -> rsp_data 0, 0, 0; err 0, 0, 1; each rsp_valid 1 cycle after accept; no LOAD selects driven.
- Assert reset during EXEC of mult -> next cycle IDLE, acc=0, rsp_valid=0, cmd_ready=1, no response emitted.
